// File: rtl/pacman_move_ctrl.sv
// Pac-Man tile-by-tile movement controller: per-frame wall/edge check, offset stepping, sprite pixel position.
// Optional turn buffer (press made mid-move is replayed on arrival) enabled by `PACMAN_TURN_BUFFER_EN.
module pacman_move_ctrl #(
    parameter int STEP          = 2,
    parameter int START_ROW     = 1,
    parameter int START_COL     = 1,
    parameter int MAZE_Y_OFFSET = 100,
    parameter int SPRITE_SIZE   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic [1:0]  level_select,
    input  logic [9:0]  tile_w,
    input  logic [9:0]  tile_h,
    input  logic [4:0]  num_rows,
    input  logic [4:0]  num_cols,
    input  logic [3:0]  walls_in,
    output logic [4:0]  wall_row,
    output logic [4:0]  wall_col,
    output logic [10:0] blkpos_x,
    output logic [10:0] blkpos_y,
    output logic [1:0]  dir,
    output logic        moving,
    output logic        blocked
);
    typedef enum logic [1:0] {IDLE, CHECK, MOVE} stateT;

    localparam logic [1:0]  DIR_UP    = 2'd0;
    localparam logic [1:0]  DIR_DOWN  = 2'd1;
    localparam logic [1:0]  DIR_LEFT  = 2'd2;
    localparam logic [1:0]  DIR_RIGHT = 2'd3;
    localparam logic [4:0]  START_ROW_L = 5'(START_ROW);
    localparam logic [4:0]  START_COL_L = 5'(START_COL);
    localparam logic [10:0] STEP_L      = 11'(STEP);
    localparam logic [10:0] SPRITE_L    = 11'(SPRITE_SIZE);
    localparam logic [10:0] YOFF_L      = 11'(MAZE_Y_OFFSET);

    stateT       state_q, state_d;
    logic [4:0]  curRow_q, curRow_d, curCol_q, curCol_d;
    logic [9:0]  offset_q, offset_d;
    logic [1:0]  dir_q, dir_d, reqDir_q, reqDir_d;
    logic        moving_q, moving_d, blocked_q, blocked_d;
    logic [1:0]  levelSel_q;
    logic [10:0] posX_q, posX_d, posY_q, posY_d;
`ifdef PACMAN_TURN_BUFFER_EN
    logic        bufValid_q, bufValid_d;
    logic [1:0]  bufDir_q, bufDir_d;
`endif

    logic        reqValid, wallHit, atEdge;
    logic [1:0]  reqDir;
    logic [9:0]  dim;
    logic [10:0] advOffset, centreX, centreY;

    always_comb begin
        reqValid = btn_up | btn_down | btn_left | btn_right;
        if (btn_up)         reqDir = DIR_UP;
        else if (btn_down)  reqDir = DIR_DOWN;
        else if (btn_left)  reqDir = DIR_LEFT;
        else                reqDir = DIR_RIGHT;
    end

    // Wall mask is ordered top,bottom,left,right so the bit index is 3-dir.
    always_comb begin
        wallHit = walls_in[2'd3 - reqDir_q];
        case (reqDir_q)
            DIR_UP:   atEdge = (curRow_q == 5'd0);
            DIR_DOWN: atEdge = (curRow_q == num_rows - 5'd1);
            DIR_LEFT: atEdge = (curCol_q == 5'd0);
            default:  atEdge = (curCol_q == num_cols - 5'd1);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        curRow_d  = curRow_q;
        curCol_d  = curCol_q;
        offset_d  = offset_q;
        dir_d     = dir_q;
        reqDir_d  = reqDir_q;
        moving_d  = moving_q;
        blocked_d = 1'b0;
`ifdef PACMAN_TURN_BUFFER_EN
        bufValid_d = bufValid_q;
        bufDir_d   = bufDir_q;
`endif
        dim       = (dir_q == DIR_UP || dir_q == DIR_DOWN) ? tile_h : tile_w;
        advOffset = {1'b0, offset_q} + STEP_L;

        case (state_q)
            IDLE: begin
`ifdef PACMAN_TURN_BUFFER_EN
                if (bufValid_q) begin
                    reqDir_d   = bufDir_q;
                    bufValid_d = 1'b0;
                    state_d    = CHECK;
                end else
`endif
                if (frame_tick && reqValid) begin
                    reqDir_d = reqDir;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                dir_d = reqDir_q;
                if (wallHit || atEdge) begin
                    blocked_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    moving_d = 1'b1;
                    state_d  = MOVE;
                end
            end
            MOVE: begin
`ifdef PACMAN_TURN_BUFFER_EN
                if (reqValid) begin
                    bufValid_d = 1'b1;
                    bufDir_d   = reqDir;
                end
`endif
                if (frame_tick) begin
                    if (advOffset < {1'b0, dim}) begin
                        offset_d = advOffset[9:0];
                    end else begin
                        offset_d = 10'd0;
                        moving_d = 1'b0;
                        state_d  = IDLE;
                        case (dir_q)
                            DIR_UP:   curRow_d = curRow_q - 5'd1;
                            DIR_DOWN: curRow_d = curRow_q + 5'd1;
                            DIR_LEFT: curCol_d = curCol_q - 5'd1;
                            default:  curCol_d = curCol_q + 5'd1;
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A level switch abandons any move in flight and wins over a same-cycle tick.
        if (level_select != levelSel_q) begin
            state_d   = IDLE;
            curRow_d  = START_ROW_L;
            curCol_d  = START_COL_L;
            offset_d  = 10'd0;
            moving_d  = 1'b0;
            blocked_d = 1'b0;
`ifdef PACMAN_TURN_BUFFER_EN
            bufValid_d = 1'b0;
`endif
        end
    end

    always_comb begin
        centreX = ({6'd0, curCol_q} * {1'b0, tile_w}) + (({1'b0, tile_w} - SPRITE_L) >> 1);
        centreY = YOFF_L + ({6'd0, curRow_q} * {1'b0, tile_h}) + (({1'b0, tile_h} - SPRITE_L) >> 1);
        posX_d  = centreX;
        posY_d  = centreY;
        case (dir_q)
            DIR_UP:   posY_d = centreY - {1'b0, offset_q};
            DIR_DOWN: posY_d = centreY + {1'b0, offset_q};
            DIR_LEFT: posX_d = centreX - {1'b0, offset_q};
            default:  posX_d = centreX + {1'b0, offset_q};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            curRow_q   <= START_ROW_L;
            curCol_q   <= START_COL_L;
            offset_q   <= 10'd0;
            dir_q      <= DIR_UP;
            reqDir_q   <= DIR_UP;
            moving_q   <= 1'b0;
            blocked_q  <= 1'b0;
            levelSel_q <= level_select;
            posX_q     <= 11'd0;
            posY_q     <= 11'd0;
        end else begin
            state_q    <= state_d;
            curRow_q   <= curRow_d;
            curCol_q   <= curCol_d;
            offset_q   <= offset_d;
            dir_q      <= dir_d;
            reqDir_q   <= reqDir_d;
            moving_q   <= moving_d;
            blocked_q  <= blocked_d;
            levelSel_q <= level_select;
            posX_q     <= posX_d;
            posY_q     <= posY_d;
        end
    end

`ifdef PACMAN_TURN_BUFFER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bufValid_q <= 1'b0;
            bufDir_q   <= DIR_UP;
        end else begin
            bufValid_q <= bufValid_d;
            bufDir_q   <= bufDir_d;
        end
    end
`endif

    assign wall_row = curRow_q;
    assign wall_col = curCol_q;
    assign blkpos_x = posX_q;
    assign blkpos_y = posY_q;
    assign dir      = dir_q;
    assign moving   = moving_q;
    assign blocked  = blocked_q;
endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Self-checking bench for pacman_move_ctrl: table of single-tick move requests plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_pacman_move_ctrl;
    logic        clk = 1'b0;
    logic        rst, frame_tick;
    logic        btn_up, btn_down, btn_left, btn_right;
    logic [1:0]  level_select;
    logic [9:0]  tile_w, tile_h;
    logic [4:0]  num_rows, num_cols;
    logic [3:0]  walls_in;
    logic [4:0]  wall_row, wall_col;
    logic [10:0] blkpos_x, blkpos_y;
    logic [1:0]  dir;
    logic        moving, blocked;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] btns;
        logic [3:0] walls;
        logic [4:0] rows;
        logic [4:0] cols;
        logic       expBlocked;
        logic       expMoving;
        logic [1:0] expDir;
    } vecT;

    typedef struct {
        logic       expBlocked;
        logic       expMoving;
        logic [1:0] expDir;
        int         expX;
        int         expY;
    } expT;

    expT sb[$];
    vecT vecs[11];

    pacman_move_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .level_select(level_select), .tile_w(tile_w), .tile_h(tile_h),
        .num_rows(num_rows), .num_cols(num_cols), .walls_in(walls_in),
        .wall_row(wall_row), .wall_col(wall_col), .blkpos_x(blkpos_x), .blkpos_y(blkpos_y),
        .dir(dir), .moving(moving), .blocked(blocked)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setButtons(input logic [3:0] b);
        {btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyReset();
        rst = 1'b1;
        frame_tick = 1'b0;
        setButtons(4'b0000);
        walls_in = 4'b0000;
        tile_w = 10'd40;
        tile_h = 10'd40;
        num_rows = 5'd10;
        num_cols = 5'd10;
        level_select = 2'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    // One frame pulse, then two quiet cycles so the registered position settles.
    task automatic frameTick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        tick();
    endtask

    task automatic applyStimulus(input vecT v);
        expT e;
        setButtons(v.btns);
        walls_in = v.walls;
        num_rows = v.rows;
        num_cols = v.cols;
        e.expBlocked = v.expBlocked;
        e.expMoving  = v.expMoving;
        e.expDir     = v.expDir;
        e.expX       = 56;
        e.expY       = 156;
        sb.push_back(e);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
    endtask

    task automatic checkOutput(input int idx);
        expT e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard[%0d]: got empty queue, expected an entry", idx);
            return;
        end
        e = sb.pop_front();
        checkValue($sformatf("vec%0d.blocked", idx), blocked, e.expBlocked);
        checkValue($sformatf("vec%0d.moving", idx), moving, e.expMoving);
        checkValue($sformatf("vec%0d.dir", idx), dir, e.expDir);
        tick();
        checkValue($sformatf("vec%0d.blockedPulse", idx), blocked, 0);
        checkValue($sformatf("vec%0d.x", idx), blkpos_x, e.expX);
        checkValue($sformatf("vec%0d.y", idx), blkpos_y, e.expY);
    endtask

    // Starts a move with the given buttons and releases them once it is accepted.
    task automatic startMove(input logic [3:0] b);
        setButtons(b);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        setButtons(4'b0000);
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int row, col, off;
        //            btns     walls    rows   cols   blk   mov   dir
        vecs[0]  = '{4'b0001, 4'b0000, 5'd10, 5'd10, 1'b0, 1'b1, 2'd3};
        vecs[1]  = '{4'b0001, 4'b0001, 5'd10, 5'd10, 1'b1, 1'b0, 2'd3};
        vecs[2]  = '{4'b0001, 4'b0000, 5'd10, 5'd2,  1'b1, 1'b0, 2'd3};
        vecs[3]  = '{4'b0100, 4'b0100, 5'd10, 5'd10, 1'b1, 1'b0, 2'd1};
        vecs[4]  = '{4'b0100, 4'b0000, 5'd2,  5'd10, 1'b1, 1'b0, 2'd1};
        vecs[5]  = '{4'b0010, 4'b0010, 5'd10, 5'd10, 1'b1, 1'b0, 2'd2};
        vecs[6]  = '{4'b0010, 4'b1101, 5'd10, 5'd10, 1'b0, 1'b1, 2'd2};
        vecs[7]  = '{4'b1000, 4'b1000, 5'd10, 5'd10, 1'b1, 1'b0, 2'd0};
        vecs[8]  = '{4'b1010, 4'b0010, 5'd10, 5'd10, 1'b0, 1'b1, 2'd0};
        vecs[9]  = '{4'b0101, 4'b0001, 5'd10, 5'd10, 1'b0, 1'b1, 2'd1};
        vecs[10] = '{4'b0000, 4'b1111, 5'd10, 5'd10, 1'b0, 1'b0, 2'd0};

        // Reset state, including the zeroed position while reset is held.
        rst = 1'b1;
        frame_tick = 1'b0;
        setButtons(4'b0000);
        walls_in = 4'b0000;
        tile_w = 10'd40;
        tile_h = 10'd40;
        num_rows = 5'd10;
        num_cols = 5'd10;
        level_select = 2'd0;
        tick();
        tick();
        checkValue("rstHeld.x", blkpos_x, 0);
        checkValue("rstHeld.y", blkpos_y, 0);
        applyReset();
        checkValue("reset.x", blkpos_x, 56);
        checkValue("reset.y", blkpos_y, 156);
        checkValue("reset.moving", moving, 0);
        checkValue("reset.blocked", blocked, 0);
        checkValue("reset.dir", dir, 0);
        checkValue("reset.row", wall_row, 1);
        checkValue("reset.col", wall_col, 1);

        for (int i = 0; i < 11; i++) begin
            applyReset();
            applyStimulus(vecs[i]);
            checkOutput(i);
        end

        // Full right move across one 40-pixel tile.
        applyReset();
        startMove(4'b0001);
        checkValue("right.startX", blkpos_x, 56);
        checkValue("right.startMoving", moving, 1);
        col = 1;
        off = 0;
        for (int k = 1; k <= 20; k++) begin
            frameTick();
            if (off + 2 < 40) off += 2;
            else begin
                col++;
                off = 0;
            end
            checkValue($sformatf("right.x[%0d]", k), blkpos_x, col * 40 + 16 + off);
        end
        checkValue("right.col", wall_col, 2);
        checkValue("right.moving", moving, 0);

        // Up beats left; then up from row 0 is refused by the grid edge.
        applyReset();
        startMove(4'b1010);
        checkValue("up.dir", dir, 0);
        row = 1;
        off = 0;
        for (int k = 1; k <= 20; k++) begin
            frameTick();
            if (off + 2 < 40) off += 2;
            else begin
                row--;
                off = 0;
            end
            checkValue($sformatf("up.y[%0d]", k), blkpos_y, 100 + row * 40 + 16 - off);
        end
        checkValue("up.row", wall_row, 0);
        checkValue("up.x", blkpos_x, 56);
        setButtons(4'b1000);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        checkValue("topEdge.blocked", blocked, 1);
        checkValue("topEdge.moving", moving, 0);
        setButtons(4'b0000);
        tick();
        checkValue("topEdge.pulse", blocked, 0);
        checkValue("topEdge.row", wall_row, 0);

        // Level change mid-move with a coincident frame tick.
        applyReset();
        startMove(4'b0001);
        for (int k = 1; k <= 5; k++) frameTick();
        checkValue("lvl.midX", blkpos_x, 66);
        level_select = 2'd1;
        tile_w = 10'd20;
        tile_h = 10'd20;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        checkValue("lvl.moving", moving, 0);
        checkValue("lvl.blocked", blocked, 0);
        checkValue("lvl.col", wall_col, 1);
        checkValue("lvl.row", wall_row, 1);
        tick();
        checkValue("lvl.x", blkpos_x, 26);
        checkValue("lvl.y", blkpos_y, 126);
        frameTick();
        checkValue("lvl.stillX", blkpos_x, 26);

        // Reset mid-move.
        applyReset();
        startMove(4'b0001);
        for (int k = 1; k <= 5; k++) frameTick();
        rst = 1'b1;
        tick();
        checkValue("rstMove.moving", moving, 0);
        checkValue("rstMove.dir", dir, 0);
        checkValue("rstMove.x", blkpos_x, 0);
        checkValue("rstMove.col", wall_col, 1);
        rst = 1'b0;
        tick();
        tick();
        checkValue("rstMove.x2", blkpos_x, 56);
        checkValue("rstMove.y2", blkpos_y, 156);

        // Down pressed during a right move.
        applyReset();
        startMove(4'b0001);
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                setButtons(4'b0100);
                tick();
                setButtons(4'b0000);
            end
            frameTick();
        end
        checkValue("turn.col", wall_col, 2);
`ifdef PACMAN_TURN_BUFFER_EN
        checkValue("turn.moving", moving, 1);
        checkValue("turn.dir", dir, 1);
        for (int k = 1; k <= 20; k++) frameTick();
        checkValue("turn.row", wall_row, 2);
        checkValue("turn.y", blkpos_y, 196);
        checkValue("turn.x", blkpos_x, 96);
`else
        checkValue("turn.moving", moving, 0);
        checkValue("turn.dir", dir, 3);
        tick();
        tick();
        tick();
        checkValue("turn.idle", moving, 0);
        startMove(4'b0100);
        checkValue("turn.newMoving", moving, 1);
        checkValue("turn.newDir", dir, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pacman_move_ctrl.md
Name: pacman_move_ctrl

Overview:
- Sequences the Pac-Man sprite through the maze one tile at a time and produces the `blkpos_x`/`blkpos_y` pixel position consumed by the draw path.
- Once per frame tick it reads the player's buttons and checks the current tile's wall mask through the active level's tile ROM.
- It then either advances the sprite by STEP pixels or reports a blocked move.
- It sits between the button debouncers, the level ROM mux and drawcon.

Parameters:
- STEP, 2, pixels advanced per frame tick while moving.
- START_ROW, 1, tile row loaded at reset and on level change.
- START_COL, 1, tile column loaded at reset and on level change.
- MAZE_Y_OFFSET, 100, pixel row where maze row 0 begins.
- SPRITE_SIZE, 8, sprite width/height in pixels.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- frame_tick  input  1  one-cycle pulse per frame (start of vblank).
- btn_up / btn_down / btn_left / btn_right  input  1 each  debounced level buttons.
- level_select  input  2  active level.
- tile_w, tile_h  input  10 each  tile size in pixels for the active level.
- num_rows, num_cols  input  5 each  maze size in tiles.
- walls_in  input  4  wall mask of tile (wall_row, wall_col): [3]=top, [2]=bottom, [1]=left, [0]=right.
- wall_row, wall_col  output  5 each  tile address presented to the level ROM.
- blkpos_x, blkpos_y  output  11 each  sprite top-left pixel, registered.
- dir  output  2  current or last direction: 0=up, 1=down, 2=left, 3=right.
- moving  output  1  high while a tile transfer is in progress.
- blocked  output  1  one-cycle pulse when a requested move is refused.

Behaviour:
- State registers: cur_row, cur_col (5b), offset (10b), dir, and FSM state in {IDLE, CHECK, MOVE}.
- wall_row/wall_col always equal cur_row/cur_col (registered). The ROM may take up to 1 cycle.
- Reset values:
  - state=IDLE; cur_row=START_ROW; cur_col=START_COL.
  - offset=0, dir=0, moving=0, blocked=0.
  - blkpos_x=blkpos_y=0, valid from the 2nd cycle after rst deasserts.
- Direction request: priority up>down>left>right. No button pressed means no request.
- IDLE: on frame_tick with a request, latch req_dir and go to CHECK. Otherwise stay.
- CHECK (exactly 1 cycle): sample walls_in. The move is refused if either holds:
  - the wall bit for req_dir is set, or
  - the move would leave the grid: up at row 0, down at row num_rows-1, left at col 0, right at col num_cols-1.
- On refusal: pulse blocked for 1 cycle, set dir=req_dir, return to IDLE.
- Otherwise: dir=req_dir, moving=1, go to MOVE. No pixel advance happens in CHECK.
- MOVE, on each frame_tick:
  - dim = tile_h for up/down, tile_w for left/right.
  - If offset+STEP < dim: offset += STEP.
  - Else: step cur_row/cur_col by ±1 toward dir, clear offset, clear moving, go to IDLE.
  - Buttons are ignored in MOVE; a tick consumed in MOVE cannot also start a new CHECK.
- Position, registered 1 cycle after the state registers:
  - cx = cur_col*tile_w + (tile_w-SPRITE_SIZE)/2
  - cy = MAZE_Y_OFFSET + cur_row*tile_h + (tile_h-SPRITE_SIZE)/2
  - offset is added or subtracted on the axis of dir (left/up subtract).
  - Arithmetic is 11-bit unsigned and truncates.
- frame_tick arriving in CHECK is ignored.
- Level change: level_select is registered. A change in any state forces cur_row=START_ROW, cur_col=START_COL, offset=0, moving=0, state=IDLE next cycle; no blocked pulse. This has priority over a simultaneous frame_tick.
- rst has priority over everything, including mid-MOVE.

Optional Feature:
- Macro `PACMAN_TURN_BUFFER_EN`.
- With the macro: during MOVE, the most recent button request is latched into a 1-entry buffer (valid bit + dir); a newer press overwrites it.
  - On entering IDLE with the buffer valid, CHECK is entered on the very next cycle without waiting for frame_tick, and the buffer is cleared.
  - Level change or rst clears the buffer.
- Without the macro: presses during MOVE are discarded and a new move needs a fresh frame_tick in IDLE.

Test Plan:
- Reset, tile_w=tile_h=40, start (1,1), STEP=2 -> blkpos_x=56, blkpos_y=156, moving=0, blocked=0.
- Hold btn_right, walls_in=0000, num_cols=10, 21 ticks:
  - after the tick that started the move, blkpos_x stays 56;
  - after the 1st MOVE tick, blkpos_x=58;
  - after the 20th MOVE tick, cur_col=2, blkpos_x=96, moving=0.
- At (1,1), walls_in=0001, btn_right, 1 tick -> blocked high exactly 1 cycle, dir=3, blkpos unchanged. Same result at col 9 with num_cols=10 and walls_in=0000.
- btn_up and btn_left together -> dir=0, cur_row decrements after 20 MOVE ticks.
- Mid-MOVE (offset=10), level_select 0->1 -> next cycle state=IDLE, position (1,1), blkpos recentred from the new tile_w/tile_h. Repeat with rst mid-MOVE -> reset values.
- `PACMAN_TURN_BUFFER_EN` defined, btn_down pulsed during a right move -> CHECK entered the cycle after arrival with no tick, then a down move proceeds. Macro undefined -> no move until a button is pressed and the next tick arrives.
